// File: rtl/ahb_timer.sv
// rtl/ahb_timer.sv - AHB-Lite slave: 32-bit prescaled down-counter with one-shot/periodic modes and level IRQ
module ahb_timer #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        timer_IRQ
);

    localparam logic [1:0] ADDR_LOAD   = 2'd0;
    localparam logic [1:0] ADDR_VALUE  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic                      accept;
    logic [1:0]                addr_q;
    logic                      write_q;
    logic                      valid_q;

    logic                      wr_load;
    logic                      wr_ctrl;
    logic                      wr_status;
    logic                      en_rise;

    logic [31:0]               load_q;
    logic [31:0]               value_q;
    logic                      en;
    logic                      periodic;
    logic                      ie;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      expired;

    logic                      tick;
    logic                      expire;
    logic [31:0]               ctrl_rd;

    // Size, low address bits and HTRANS[0] carry no meaning for this slave.
    logic unused_bus_bits;
    assign unused_bus_bits = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE};

    assign accept = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            addr_q  <= 2'd0;
            write_q <= 1'b0;
        end else if (HREADY) begin
            valid_q <= accept;
            if (accept) begin
                addr_q  <= HADDR[3:2];
                write_q <= HWRITE;
            end
        end
    end

    assign wr_load   = valid_q & write_q & (addr_q == ADDR_LOAD);
    assign wr_ctrl   = valid_q & write_q & (addr_q == ADDR_CTRL);
    assign wr_status = valid_q & write_q & (addr_q == ADDR_STATUS);
    assign en_rise   = wr_ctrl & HWDATA[0] & ~en;

    // >= keeps the prescaler from running off to its full range if PRESCALE is lowered mid-count.
    assign tick   = en & (pre_cnt >= prescale);
    assign expire = tick & (value_q == 32'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            load_q <= 32'd0;
        end else if (wr_load) begin
            load_q <= HWDATA;
        end
    end

    // A CTRL write owns EN even when a one-shot expiry lands on the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            en       <= HWDATA[0];
            periodic <= HWDATA[1];
            ie       <= HWDATA[2];
            prescale <= HWDATA[8 +: PRESCALE_WIDTH];
        end else if (expire && !periodic) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre_cnt <= '0;
        end else if (wr_load || en_rise) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            value_q <= 32'd0;
        end else if (wr_load) begin
            value_q <= HWDATA;
        end else if (tick) begin
            if (value_q != 32'd0) begin
                value_q <= value_q - 32'd1;
            end else if (periodic) begin
                value_q <= load_q;
            end
        end
    end

    // Expiry beats a same-cycle write-1-to-clear so no event is ever lost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && HWDATA[0]) begin
            expired <= 1'b0;
        end
    end

    always_comb begin
        ctrl_rd                        = 32'd0;
        ctrl_rd[0]                     = en;
        ctrl_rd[1]                     = periodic;
        ctrl_rd[2]                     = ie;
        ctrl_rd[8 +: PRESCALE_WIDTH]   = prescale;
    end

    always_comb begin
        HRDATA = 32'd0;
        if (valid_q) begin
            case (addr_q)
                ADDR_LOAD:   HRDATA = load_q;
                ADDR_VALUE:  HRDATA = value_q;
                ADDR_CTRL:   HRDATA = ctrl_rd;
                ADDR_STATUS: HRDATA = {31'd0, expired};
                default:     HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign timer_IRQ = expired & ie;

endmodule

// File: doc/ahb_timer.md
# ahb_timer

AHB-Lite slave providing a programmable 32-bit down-counting timer with prescaler, one-shot/periodic modes and a level interrupt. Sits on the system bus as decoder slave S5, alongside GPIO, UART and SPI. Its read data and ready outputs go to the bus multiplexer. Its interrupt drives processor IRQ[0], which is currently tied low.

## Interface
Parameters:
- PRESCALE_WIDTH, 8, width of the prescaler field and of the prescaler counter.

Ports:
- HCLK  input  1  system bus clock (50 MHz). The block uses only this clock.
- HRESETn  input  1  bus reset. Asynchronous, active-low.
- HSEL  input  1  slave select from the address decoder.
- HREADY  input  1  bus ready; the previous transfer is completing.
- HADDR  input  32  address; only bits [3:2] are decoded.
- HTRANS  input  2  transfer type; only bit 1 is used.
- HWRITE  input  1  write transfer.
- HSIZE  input  3  transfer width; ignored, every access is a full word.
- HWDATA  input  32  write data, valid in the data phase.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  slave ready; tied to 1, so there are no wait states.
- timer_IRQ  output  1  level interrupt to the CPU.

## Operation
Register map (word offsets, selected by HADDR[3:2]):
- 0x0 LOAD: read/write, 32 bits. A write also loads VALUE and clears the prescaler counter.
- 0x4 VALUE: read-only, current count. Writes are ignored.
- 0x8 CTRL: read/write.
  - bit0 EN: enable.
  - bit1 PERIODIC: 1 = periodic, 0 = one-shot.
  - bit2 IE: interrupt enable.
  - bits[8+PRESCALE_WIDTH-1:8] PRESCALE.
  - Other bits read 0.
  - Writing EN from 0 to 1 clears the prescaler counter.
- 0xC STATUS: bit0 EXPIRED. Writing 1 to bit0 clears it; writing 0 has no effect. Other bits read 0.

AHB behaviour:
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register the address bits, a write flag and a valid flag.
- Write: performed in the data phase, using the registered address and HWDATA.
- Read: HRDATA is combinationally muxed from the registered address.
- HRDATA is 0 when the registered valid flag is low.

Counter operation:
- The prescaler counter runs only while EN=1.
- It counts 0..PRESCALE. Wrapping from PRESCALE to 0 produces a one-cycle `tick`. With PRESCALE=0, `tick` occurs every cycle.
- On `tick` with VALUE≠0: VALUE decrements by 1.
- On `tick` with VALUE=0 (expiry):
  - EXPIRED is set.
  - If PERIODIC=1, VALUE reloads from LOAD.
  - If PERIODIC=0, EN clears and VALUE stays 0.
- Period: (LOAD+1)·(PRESCALE+1) HCLK cycles between expiries in periodic mode.
- timer_IRQ = EXPIRED & IE. It is level-sensitive and stays asserted until software clears EXPIRED.
- Clearing EN freezes VALUE and the prescaler counter. Re-enabling continues VALUE from where it stopped; the prescaler restarts at 0.

Simultaneous events:
- Expiry and a write-1-to-clear of EXPIRED in the same cycle: set wins, EXPIRED=1.
- A LOAD write and a `tick` in the same cycle: the write wins. VALUE=new LOAD and the prescaler is cleared.
- A CTRL write and a one-shot expiry in the same cycle: the CTRL write value is used for EN. EXPIRED is still set.
- Arithmetic is unsigned. VALUE never wraps below 0.

## Timing
- Reset (asynchronous assert, synchronous-to-HCLK deassert from the reset generator): LOAD, VALUE, CTRL, EXPIRED, the prescaler counter and the registered address-phase state are all 0. Outputs: HRDATA=0, HREADYOUT=1, timer_IRQ=0.
- Reset asserted mid-count: all state clears immediately and the timer stops.
- Write: address phase in cycle N, data phase in N+1. The register updates at the HCLK edge ending N+1 and is visible from N+2.
- Read: address phase in N; HRDATA is valid throughout N+1.
- Back-to-back write then read of the same register returns the new value.
- A VALUE read returns the count as of that data-phase cycle.
- `tick` to VALUE update: the register updates on the same edge (1 cycle).
- Expiry edge to timer_IRQ high: timer_IRQ is high from the cycle after that edge. EXPIRED is a flop and timer_IRQ is combinational from flops.
- First expiry after enable: (LOAD+1)·(PRESCALE+1) cycles after the EN-set edge.

## Test plan
- Reset: assert HRESETn low mid-count with EN=1 → all registers read 0, timer_IRQ=0, HREADYOUT=1 throughout.
- Periodic: LOAD=4, PRESCALE=1, CTRL=0x7 → EXPIRED sets every 10 cycles. timer_IRQ stays high until STATUS is written with 0x1. VALUE sequence read back is 4,4,3,3,…,0,0,4.
- One-shot: LOAD=3, PRESCALE=0, CTRL=0x5 → expiry after 4 cycles. CTRL reads 0x4, VALUE stays 0, timer_IRQ=1.
- Collision: arrange a write of 1 to STATUS in the same cycle as an expiry → EXPIRED reads 1 afterwards.
- LOAD write during count: counter running at VALUE=100; write LOAD=7 → next VALUE read is 7 and the prescaler restarts.
- Bus: back-to-back write LOAD=0xDEADBEEF, then read LOAD, then read VALUE → HRDATA=0xDEADBEEF, then the current VALUE. A write to VALUE is ignored. An access with HTRANS=IDLE has no effect.
